// File: rtl/sweep_sequencer.sv
// Run controller for the banked grid-sweep array: launches all sweep machines together,
// re-launches while any machine reports a change, then serially sums per-machine update counts.
module sweep_sequencer #(
    parameter int MACH_N     = 4,
    parameter int UPD_W      = 32,
    parameter int MAX_PASSES = 256,
    parameter int PASS_W     = $clog2(MAX_PASSES + 1),
    parameter int SUM_W      = UPD_W + $clog2(MACH_N) + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run_in,
    input  logic                     staging_in,
    input  logic                     single_pass_in,
    input  logic [MACH_N-1:0]        mach_done_in,
    input  logic [MACH_N-1:0]        mach_changed_in,
    input  logic [MACH_N*UPD_W-1:0]  mach_updates_in,
    output logic [MACH_N-1:0]        mach_run_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [PASS_W-1:0]        passes_out,
    output logic                     timeout_out,
    output logic [SUM_W-1:0]         updates_out
);

    localparam int IDX_W = (MACH_N > 1) ? $clog2(MACH_N) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_GUARD  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_SUM    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [PASS_W-1:0] passes_q, passes_d;
    logic             timeout_q, timeout_d;
    logic [SUM_W-1:0] updates_q, updates_d;
    logic [IDX_W-1:0] idx_q,     idx_d;
    logic             single_q,  single_d;

    logic [UPD_W-1:0] slice;
    logic [SUM_W-1:0] addend;

    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < MACH_N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice = mach_updates_in[i*UPD_W +: UPD_W];
            end
        end
        addend = {{(SUM_W-UPD_W){1'b0}}, slice};
    end

    always_comb begin
        state_d   = state_q;
        passes_d  = passes_q;
        timeout_d = timeout_q;
        updates_d = updates_q;
        idx_d     = idx_q;
        single_d  = single_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (run_in && !staging_in) begin
                    state_d   = S_LAUNCH;
                    passes_d  = '0;
                    timeout_d = 1'b0;
                    updates_d = '0;
                    single_d  = single_pass_in;
                end
            end
            S_LAUNCH: begin
                passes_d = passes_q + PASS_W'(1);
                state_d  = S_GUARD;
            end
            // Done bits left over from the previous pass are deliberately not looked at here.
            S_GUARD: state_d = S_WAIT;
            S_WAIT: begin
                if (&mach_done_in) begin
                    if (single_q || !(|mach_changed_in)) begin
                        state_d = S_SUM;
                    end else if (passes_q == PASS_W'(MAX_PASSES)) begin
                        timeout_d = 1'b1;
                        state_d   = S_SUM;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_SUM: begin
                updates_d = updates_q + addend;
                if (idx_q == IDX_W'(MACH_N - 1)) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            passes_q  <= '0;
            timeout_q <= 1'b0;
            updates_q <= '0;
            idx_q     <= '0;
            single_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            passes_q  <= passes_d;
            timeout_q <= timeout_d;
            updates_q <= updates_d;
            idx_q     <= idx_d;
            single_q  <= single_d;
        end
    end

    assign mach_run_out = {MACH_N{state_q == S_LAUNCH}};
    assign busy_out     = (state_q == S_LAUNCH) || (state_q == S_GUARD) ||
                          (state_q == S_WAIT)   || (state_q == S_SUM);
    assign done_out     = (state_q == S_DONE);
    assign passes_out   = passes_q;
    assign timeout_out  = timeout_q;
    assign updates_out  = updates_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Directed bench for sweep_sequencer: a 4-machine instance with a pass limit of 3
// and a single-machine instance for the one-cycle sum.
module tb_sweep_sequencer;

    localparam int UPD_W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run_in = 1'b0;
    logic          staging_in = 1'b0;
    logic          single_pass_in = 1'b0;
    logic [3:0]    mach_done_in = '0;
    logic [3:0]    mach_changed_in = '0;
    logic [127:0]  mach_updates_in = '0;
    logic [3:0]    mach_run_out;
    logic          busy_out, done_out, timeout_out;
    logic [1:0]    passes_out;
    logic [34:0]   updates_out;

    logic          run1 = 1'b0;
    logic          done1 = 1'b0;
    logic          chg1 = 1'b0;
    logic [31:0]   upd1 = '0;
    logic          run_out1, busy1, done_out1, timeout1;
    logic [8:0]    passes1;
    logic [32:0]   updates1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    sweep_sequencer #(.MACH_N(4), .UPD_W(UPD_W), .MAX_PASSES(3)) dut (
        .clock(clock), .reset(reset), .run_in(run_in), .staging_in(staging_in),
        .single_pass_in(single_pass_in), .mach_done_in(mach_done_in),
        .mach_changed_in(mach_changed_in), .mach_updates_in(mach_updates_in),
        .mach_run_out(mach_run_out), .busy_out(busy_out), .done_out(done_out),
        .passes_out(passes_out), .timeout_out(timeout_out), .updates_out(updates_out)
    );

    sweep_sequencer #(.MACH_N(1), .UPD_W(UPD_W), .MAX_PASSES(256)) dut1 (
        .clock(clock), .reset(reset), .run_in(run1), .staging_in(1'b0),
        .single_pass_in(1'b0), .mach_done_in(done1),
        .mach_changed_in(chg1), .mach_updates_in(upd1),
        .mach_run_out(run_out1), .busy_out(busy1), .done_out(done_out1),
        .passes_out(passes1), .timeout_out(timeout1), .updates_out(updates1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called while the DUT sits in LAUNCH; returns right after the edge that leaves WAIT.
    task automatic complete_pass(input logic [3:0] chg, input int late);
        tick();
        tick();
        repeat (late) tick();
        mach_done_in    = 4'hF;
        mach_changed_in = chg;
        tick();
        mach_done_in    = '0;
        mach_changed_in = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_run",     64'(mach_run_out), 64'h0);
        chk("rst_busy",    64'(busy_out),     64'h0);
        chk("rst_done",    64'(done_out),     64'h0);
        chk("rst_passes",  64'(passes_out),   64'h0);
        chk("rst_timeout", 64'(timeout_out),  64'h0);
        chk("rst_updates", 64'(updates_out),  64'h0);
        reset = 1'b0;

        // staging blocks the launch; dropping it launches one cycle later
        mach_updates_in = {32'd1, 32'd7, 32'd0, 32'd5};
        run_in = 1'b1;
        staging_in = 1'b1;
        tick();
        chk("stage_norun", 64'(mach_run_out), 64'h0);
        tick();
        chk("stage_idle",  64'(busy_out),     64'h0);
        staging_in = 1'b0;
        tick();
        run_in = 1'b0;
        chk("stage_pulse", 64'(mach_run_out), 64'hF);
        tick();
        chk("p1_pulse_end", 64'(mach_run_out), 64'h0);
        chk("p1_passes",    64'(passes_out),   64'h1);
        tick();
        mach_done_in = 4'hF;
        mach_changed_in = 4'hF;
        tick();
        mach_done_in = '0;
        mach_changed_in = '0;
        chk("p2_pulse", 64'(mach_run_out), 64'hF);
        complete_pass(4'h2, 0);
        chk("p3_pulse", 64'(mach_run_out), 64'hF);
        complete_pass(4'h0, 0);
        chk("p3_nopulse", 64'(mach_run_out), 64'h0);
        chk("p3_sumbusy", 64'(busy_out),     64'h1);
        tick(); tick(); tick();
        chk("sum_not_done", 64'(done_out), 64'h0);
        tick();
        chk("t3_done",    64'(done_out),    64'h1);
        chk("t3_busy",    64'(busy_out),    64'h0);
        chk("t3_passes",  64'(passes_out),  64'h3);
        tick();
        chk("t3_updates", 64'(updates_out), 64'd13);
        chk("t3_timeout", 64'(timeout_out), 64'h0);

        // reset while in WAIT with a would-be relaunch pending
        run_in = 1'b1;
        tick();
        run_in = 1'b0;
        chk("r_pulse", 64'(mach_run_out), 64'hF);
        tick();
        tick();
        mach_done_in = 4'hF;
        mach_changed_in = 4'hF;
        reset = 1'b1;
        tick();
        chk("r_run",     64'(mach_run_out), 64'h0);
        chk("r_busy",    64'(busy_out),     64'h0);
        chk("r_done",    64'(done_out),     64'h0);
        chk("r_passes",  64'(passes_out),   64'h0);
        chk("r_updates", 64'(updates_out),  64'h0);
        chk("r_timeout", 64'(timeout_out),  64'h0);
        reset = 1'b0;
        mach_done_in = '0;
        mach_changed_in = '0;
        tick();
        chk("r_nopulse", 64'(mach_run_out), 64'h0);
        chk("r_idle",    64'(busy_out),     64'h0);

        // single pass despite changes
        mach_updates_in = {32'd400, 32'd300, 32'd200, 32'd100};
        single_pass_in = 1'b1;
        run_in = 1'b1;
        tick();
        run_in = 1'b0;
        single_pass_in = 1'b0;
        chk("sp_pulse", 64'(mach_run_out), 64'hF);
        complete_pass(4'hF, 2);
        for (int k = 0; k < 4; k++) begin
            chk("sp_nopulse", 64'(mach_run_out), 64'h0);
            chk("sp_done_lat", 64'(done_out), 64'h0);
            tick();
        end
        chk("sp_done",    64'(done_out),    64'h1);
        chk("sp_passes",  64'(passes_out),  64'h1);
        chk("sp_updates", 64'(updates_out), 64'd1000);
        chk("sp_timeout", 64'(timeout_out), 64'h0);

        // pass limit with changes always present
        mach_updates_in = {32'd4, 32'd3, 32'd2, 32'd1};
        run_in = 1'b1;
        tick();
        run_in = 1'b0;
        chk("to_pulse1", 64'(mach_run_out), 64'hF);
        complete_pass(4'hF, 0);
        chk("to_pulse2", 64'(mach_run_out), 64'hF);
        complete_pass(4'h8, 1);
        chk("to_pulse3", 64'(mach_run_out), 64'hF);
        complete_pass(4'h1, 0);
        chk("to_nopulse", 64'(mach_run_out), 64'h0);
        chk("to_flag",    64'(timeout_out),  64'h1);
        tick(); tick(); tick(); tick();
        chk("to_done",    64'(done_out),    64'h1);
        chk("to_passes",  64'(passes_out),  64'h3);
        chk("to_updates", 64'(updates_out), 64'd10);

        // restart from DONE, stale done across GUARD, machine 2 ten cycles late
        mach_updates_in = {32'd40, 32'd30, 32'd20, 32'd10};
        run_in = 1'b1;
        tick();
        run_in = 1'b0;
        chk("st_pulse",   64'(mach_run_out), 64'hF);
        chk("st_clr_upd", 64'(updates_out),  64'h0);
        chk("st_clr_to",  64'(timeout_out),  64'h0);
        chk("st_clr_pas", 64'(passes_out),   64'h0);
        mach_done_in = 4'hF;
        mach_changed_in = 4'hF;
        tick();
        chk("st_guard", 64'(mach_run_out), 64'h0);
        tick();
        chk("st_noearly", 64'(mach_run_out), 64'h0);
        mach_done_in = 4'b1011;
        run_in = 1'b1;
        staging_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("st_wait", 64'(mach_run_out), 64'h0);
        end
        chk("st_busy", 64'(busy_out), 64'h1);
        run_in = 1'b0;
        mach_done_in = 4'hF;
        mach_changed_in = 4'b0100;
        tick();
        mach_done_in = '0;
        mach_changed_in = '0;
        chk("st_relaunch", 64'(mach_run_out), 64'hF);
        staging_in = 1'b0;
        complete_pass(4'h0, 3);
        tick(); tick(); tick(); tick();
        chk("st_done",    64'(done_out),    64'h1);
        chk("st_passes",  64'(passes_out),  64'h2);
        chk("st_updates", 64'(updates_out), 64'd100);

        // single machine: the sum takes one cycle
        upd1 = 32'd77;
        run1 = 1'b1;
        tick();
        run1 = 1'b0;
        chk("m1_pulse", 64'(run_out1), 64'h1);
        tick();
        tick();
        done1 = 1'b1;
        tick();
        done1 = 1'b0;
        chk("m1_sum",     64'(busy1),     64'h1);
        tick();
        chk("m1_done",    64'(done_out1), 64'h1);
        chk("m1_updates", 64'(updates1),  64'd77);
        chk("m1_passes",  64'(passes1),   64'h1);
        chk("m1_timeout", 64'(timeout1),  64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
